// File: rtl/fir_seq_mac_if.sv
// Sequencing stream from the sample queue into the FIR engine, plus its result port.
interface fir_seq_mac_if;
  localparam int unsigned SMPL_W = 16;

  logic                     sequencing;
  logic signed [SMPL_W-1:0] smpl_in;
  logic signed [SMPL_W-1:0] smpl_out;
  logic                     valid;
  logic                     seq_err;

  // Queue side drives the burst and watches the result.
  modport master (
    output sequencing,
    output smpl_in,
    input  smpl_out,
    input  valid,
    input  seq_err
  );

  // FIR engine side.
  modport slave (
    input  sequencing,
    input  smpl_in,
    output smpl_out,
    output valid,
    output seq_err
  );
endinterface

// File: rtl/fir_seq_mac.sv
// Serial FIR engine: one tap-weighted MAC per burst sample, one saturated result per burst.
// Coefficient ROM image is the COEFF_INIT vector, tap i at bits [16*i +: 16], Q1.15.
module fir_seq_mac #(
  parameter int unsigned            NUM_TAPS   = 1021,
  parameter int unsigned            ACC_W      = 42,
  parameter logic [NUM_TAPS*16-1:0] COEFF_INIT = '0
) (
  input logic          clk,
  input logic          rst_n,
  fir_seq_mac_if.slave bus
);
  localparam int unsigned SMPL_W = 16;
  localparam int unsigned PROD_W = 2 * SMPL_W;
  localparam int unsigned FRAC_W = 15;
  localparam int unsigned SH_W   = ACC_W - FRAC_W;
  localparam int unsigned CNT_W  = $clog2(NUM_TAPS + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_TAPS * SMPL_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     armed_q;
  logic                     err_q;
  logic signed [SMPL_W-1:0] s1_q, c1_q;
  logic signed [PROD_W-1:0] p2_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic                     start_c, take_c, drop_c, emit_c;
  logic [CNT_W-1:0]         addr_c;
  logic [IDX_W-1:0]         rom_idx_c;
  logic signed [SMPL_W-1:0] rom_c;
  logic signed [SH_W-1:0]   sh_c;
  logic signed [SMPL_W-1:0] sat_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a burst only opens once sequencing has been seen low in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sequencing && armed_q) state_d = ACCUM;
      ACCUM:   if (!bus.sequencing) state_d = DRAIN;
      DRAIN:   state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM decode: start/take a sample, drop a sample, emit the result.
  always_comb begin
    start_c = 1'b0;
    take_c  = 1'b0;
    drop_c  = 1'b0;
    emit_c  = 1'b0;
    case (state_q)
      IDLE: begin
        start_c = bus.sequencing && armed_q;
        take_c  = bus.sequencing && armed_q;
      end
      ACCUM:   take_c = bus.sequencing;
      DRAIN:   drop_c = bus.sequencing;
      OUTPUT: begin
        drop_c = bus.sequencing;
        emit_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Arm for a new burst after a low sequencing cycle observed while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= (state_q == IDLE) && !bus.sequencing;
  end

  // Tap counter (saturating at NUM_TAPS) and sticky burst error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (start_c) begin
      cnt_q <= CNT_W'(1);
      err_q <= 1'b0;
    end else begin
      if (take_c && (cnt_q != LAST)) cnt_q <= cnt_q + CNT_W'(1);
      if ((take_c && (cnt_q == LAST)) || drop_c) err_q <= 1'b1;
    end
  end

  // ROM address and lookup; taps past the end read as zero.
  always_comb begin
    addr_c    = start_c ? '0 : cnt_q;
    rom_idx_c = IDX_W'(addr_c) * IDX_W'(SMPL_W);
    rom_c     = '0;
    if (take_c && (addr_c != LAST)) rom_c = COEFF_INIT[rom_idx_c +: SMPL_W];
  end

  // Three-stage MAC pipeline; idle slots carry zeros so smpl_in is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      c1_q  <= '0;
      p2_q  <= '0;
      acc_q <= '0;
    end else begin
      s1_q  <= take_c ? bus.smpl_in : '0;
      c1_q  <= rom_c;
      p2_q  <= PROD_W'(s1_q) * PROD_W'(c1_q);
      acc_q <= start_c ? '0 : acc_q + ACC_W'(p2_q);
    end
  end

  // Q1.15 rescale by arithmetic shift, then saturate to 16 bits.
  always_comb begin
    sh_c = SH_W'(acc_q >>> FRAC_W);
    if (!sh_c[SH_W-1] && (|sh_c[SH_W-2:SMPL_W-1]))      sat_c = 16'sh7FFF;
    else if (sh_c[SH_W-1] && !(&sh_c[SH_W-2:SMPL_W-1])) sat_c = 16'sh8000;
    else                                                 sat_c = sh_c[SMPL_W-1:0];
  end

  // Result registers: sample held between bursts, valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.smpl_out <= '0;
      bus.valid    <= 1'b0;
      bus.seq_err  <= 1'b0;
    end else begin
      bus.valid <= emit_c;
      if (emit_c) begin
        bus.smpl_out <= sat_c;
        bus.seq_err  <= err_q || drop_c || (cnt_q != LAST);
      end
    end
  end
endmodule

// File: tb/tb_fir_seq_mac.sv
// Scoreboard bench for fir_seq_mac: four instances with different coefficient images.
module tb_fir_seq_mac;
  localparam int unsigned NI  = 4;
  localparam int unsigned BIG = 1021;

  function automatic logic [BIG*16-1:0] make_coeff();
    logic [BIG*16-1:0] v;
    v = '0;
    for (int i = 0; i < int'(BIG); i++) v[i*16 +: 16] = 16'(i * 53 - 12345);
    return v;
  endfunction

  localparam logic [63:0]       ROM_A = {16'h0000, 16'h0000, 16'h4000, 16'h4000};
  localparam logic [63:0]       ROM_B = {4{16'h7FFF}};
  localparam logic [63:0]       ROM_C = {4{16'h4000}};
  localparam logic [BIG*16-1:0] ROM_D = make_coeff();

  typedef struct {
    int          id;
    logic [15:0] val;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];

  logic [NI-1:0] seq_d;
  logic [15:0]   din_d [NI];
  logic [NI-1:0] vld_m;
  logic [NI-1:0] err_m;
  logic [15:0]   out_m [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_seq_mac_if if_a ();
  fir_seq_mac_if if_b ();
  fir_seq_mac_if if_c ();
  fir_seq_mac_if if_d ();

  fir_seq_mac #(.NUM_TAPS(4),   .ACC_W(42), .COEFF_INIT(ROM_A)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fir_seq_mac #(.NUM_TAPS(4),   .ACC_W(42), .COEFF_INIT(ROM_B)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  fir_seq_mac #(.NUM_TAPS(4),   .ACC_W(42), .COEFF_INIT(ROM_C)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  fir_seq_mac #(.NUM_TAPS(BIG), .ACC_W(42), .COEFF_INIT(ROM_D)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  assign if_a.sequencing = seq_d[0];  assign if_a.smpl_in = din_d[0];
  assign if_b.sequencing = seq_d[1];  assign if_b.smpl_in = din_d[1];
  assign if_c.sequencing = seq_d[2];  assign if_c.smpl_in = din_d[2];
  assign if_d.sequencing = seq_d[3];  assign if_d.smpl_in = din_d[3];
  assign vld_m = {if_d.valid, if_c.valid, if_b.valid, if_a.valid};
  assign err_m = {if_d.seq_err, if_c.seq_err, if_b.seq_err, if_a.seq_err};
  assign out_m[0] = if_a.smpl_out;
  assign out_m[1] = if_b.smpl_out;
  assign out_m[2] = if_c.smpl_out;
  assign out_m[3] = if_d.smpl_out;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n samples on instance id, optionally expecting a result 3 clks after the last one.
  task automatic burst(input int id, input logic [15:0] s [8], input int n,
                       input bit push, input logic [15:0] ev, input logic ee);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      seq_d[id] = 1'b1;
      din_d[id] = s[k];
    end
    if (push) begin
      e.id = id; e.val = ev; e.err = ee; e.due = cyc + 4;
      sb.push_back(e);
    end
    @(negedge clk);
    seq_d[id] = 1'b0;
    din_d[id] = 16'($urandom);
  endtask

  // Monitor: every valid pulse must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < int'(NI); i++) begin
      if (vld_m[i]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: dut %0d pulsed valid (out %h) with nothing expected", i, out_m[i]);
        end else begin
          e = sb.pop_front();
          if (e.id != i || e.val !== out_m[i] || e.err !== err_m[i] || e.due != cyc) begin
            n_bad++;
            $display("FAIL result: got dut %0d out %h err %0b cyc %0d, expected dut %0d out %h err %0b cyc %0d",
                     i, out_m[i], err_m[i], cyc, e.id, e.val, e.err, e.due);
          end
        end
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_valid: dut %0d expected out %h at cyc %0d, valid did not pulse", sb[0].id, sb[0].val, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin : stim
    exp_t e;
    rst_n = 1'b0;
    seq_d = '0;
    for (int i = 0; i < int'(NI); i++) din_d[i] = 16'h0;
    idle(3);
    for (int i = 0; i < int'(NI); i++) begin
      chk("reset_smpl_out", 32'(out_m[i]), 32'h0);
      chk("reset_valid",    32'(vld_m[i]), 32'h0);
    end
    chk("reset_seq_err", 32'(err_m), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Nominal burst, taps 0.5/0.5/0/0: (100+200)/2.
    burst(0, '{16'd100, 16'd200, 16'd7, 16'd9, 0, 0, 0, 0}, 4, 1'b1, 16'd150, 1'b0);
    idle(4);
    // Negative product truncates toward -inf: -3*0.5 = -1.5 -> -2.
    burst(0, '{16'hFFFD, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0}, 4, 1'b1, 16'hFFFE, 1'b0);
    idle(4);
    // 1-clk burst: 1000*0.5, short burst flagged.
    burst(0, '{16'd1000, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1, 16'd500, 1'b1);
    idle(4);

    // Saturation both ways.
    burst(1, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0}, 4, 1'b1, 16'h7FFF, 1'b0);
    idle(4);
    burst(1, '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0, 0}, 4, 1'b1, 16'h8000, 1'b0);
    idle(4);

    // Short and long bursts on all-0.5 taps.
    burst(2, '{16'd100, 16'd100, 16'd100, 0, 0, 0, 0, 0}, 3, 1'b1, 16'd150, 1'b1);
    idle(4);
    burst(2, '{16'd100, 16'd100, 16'd100, 16'd100, 16'd50, 16'd50, 0, 0}, 6, 1'b1, 16'd200, 1'b1);
    idle(4);

    // Reset two clks into a burst: everything clears, no result.
    @(negedge clk); seq_d[2] = 1'b1; din_d[2] = 16'd100;
    @(negedge clk); din_d[2] = 16'd100;
    @(negedge clk); rst_n = 1'b0; seq_d[2] = 1'b0;
    idle(2);
    chk("midreset_smpl_out", 32'(out_m[2]), 32'h0);
    chk("midreset_seq_err",  32'(err_m[2]), 32'h0);
    chk("midreset_valid",    32'(vld_m[2]), 32'h0);
    rst_n = 1'b1;
    idle(2);
    burst(2, '{16'd100, 16'd100, 16'd100, 16'd100, 0, 0, 0, 0}, 4, 1'b1, 16'd200, 1'b0);
    idle(4);

    // 1-clk gap: second burst lands in DRAIN/OUTPUT and is dropped.
    burst(0, '{16'd100, 16'd200, 16'd7, 16'd9, 0, 0, 0, 0}, 4, 1'b1, 16'd150, 1'b1);
    burst(0, '{16'd500, 16'd500, 16'd500, 16'd500, 0, 0, 0, 0}, 4, 1'b0, 16'd0, 1'b0);
    idle(6);
    // 4-clk gap: two clean results.
    burst(0, '{16'd100, 16'd200, 16'd7, 16'd9, 0, 0, 0, 0}, 4, 1'b1, 16'd150, 1'b0);
    idle(3);
    burst(0, '{16'd40, 16'd60, 16'd1, 16'd1, 0, 0, 0, 0}, 4, 1'b1, 16'd50, 1'b0);
    idle(4);

    // Full-length impulse on the 1021-tap instance: coeff[0] = -12345, floor(-12345*32767/32768).
    for (int k = 0; k < int'(BIG); k++) begin
      @(negedge clk);
      seq_d[3] = 1'b1;
      din_d[3] = (k == 0) ? 16'h7FFF : 16'h0000;
    end
    e.id = 3; e.val = 16'hCFC7; e.err = 1'b0; e.due = cyc + 4;
    sb.push_back(e);
    @(negedge clk);
    seq_d[3] = 1'b0;
    idle(10);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
